// File: rtl/gpio_pb_frontend.sv
// GPIO front-end: button sync/debounce/edge-detect/keycode encoding, plus a registered output window.
// Define AUTO_REPEAT_EN to add per-button auto-repeat pulses every REPEAT_CYCLES while held.
module gpio_pb_frontend #(
    parameter int GPIO_W        = 34,
    parameter int NUM_PB        = 10,
    parameter int NUM_OUT       = 16,
    parameter int OUT_BASE      = 10,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 8,
    localparam int CODE_W       = (NUM_PB > 1) ? $clog2(NUM_PB) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ncs,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oeb,
    input  logic [NUM_OUT-1:0] dout,
    output logic [NUM_PB-1:0] pb_level,
    output logic [NUM_PB-1:0] pb_pulse,
    output logic              pb_valid,
    output logic [CODE_W-1:0] pb_code,
    output logic              pb_multi
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [GPIO_W-1:0] WIN =
        {{(GPIO_W - NUM_OUT){1'b0}}, {NUM_OUT{1'b1}}} << OUT_BASE;

    if (OUT_BASE < NUM_PB || OUT_BASE + NUM_OUT > GPIO_W) begin : g_bad_window
        $error("gpio_pb_frontend: output window overlaps buttons or exceeds GPIO_W");
    end
    if (DB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
        $error("gpio_pb_frontend: DB_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    // Pins outside the button field are inputs we deliberately ignore.
    logic unused_pins;
    assign unused_pins = &{1'b0, gpio_in[GPIO_W-1:NUM_PB]};

    // Deselect behaves exactly like reset for every piece of state.
    logic clr;
    assign clr = !n_rst || ncs;

    logic [NUM_PB-1:0] sync1, sync2;
    logic [NUM_PB-1:0] lvl_nxt;
    logic [NUM_PB-1:0] rep;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
        logic [CNT_W-1:0] cnt;
        logic             mis;
        logic             hit;

        assign mis        = sync2[i] != pb_level[i];
        assign hit        = mis && (cnt == CNT_W'(DB_CYCLES - 1));
        assign lvl_nxt[i] = hit ? ~pb_level[i] : pb_level[i];

        // Any matching sample restarts the stability count.
        always_ff @(posedge clk) begin
            if (clr || !mis || hit)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end

`ifdef AUTO_REPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES + 1);
        logic [RW-1:0] rcnt;
        logic          held;
        logic          wrap;

        assign held   = pb_level[i] && lvl_nxt[i];
        assign wrap   = rcnt == RW'(REPEAT_CYCLES - 1);
        assign rep[i] = held && wrap;

        always_ff @(posedge clk) begin
            if (clr || !held || wrap)
                rcnt <= '0;
            else
                rcnt <= rcnt + RW'(1);
        end
`else
        assign rep[i] = 1'b0;
`endif
    end

    logic [CODE_W-1:0] code_nxt;
    logic              multi_nxt;

    always_comb begin
        code_nxt = '0;
        for (int i = NUM_PB - 1; i >= 0; i--)
            if (pb_pulse[i]) code_nxt = CODE_W'(i);
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_nxt = (pb_pulse & (pb_pulse - NUM_PB'(1))) != '0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1    <= '0;
            sync2    <= '0;
            pb_level <= '0;
            pb_pulse <= '0;
            pb_valid <= 1'b0;
            pb_code  <= '0;
            pb_multi <= 1'b0;
            gpio_out <= '0;
            gpio_oeb <= '1;
        end else begin
            sync1    <= gpio_in[NUM_PB-1:0];
            sync2    <= sync1;
            pb_level <= lvl_nxt;
            pb_pulse <= (lvl_nxt & ~pb_level) | rep;
            pb_valid <= |pb_pulse;
            pb_code  <= code_nxt;
            pb_multi <= multi_nxt;
            gpio_out <= GPIO_W'(dout) << OUT_BASE;
            gpio_oeb <= ~WIN;
        end
    end

endmodule
